// File: rtl/branch_update_queue_if.sv
// Execute-stage resolution port and BTB update port of branch_update_queue.
// The master side is the execute stage and the BTB together; the queue itself is the slave.
interface branch_update_queue_if #(
  parameter int CNT_W = 3
);
  logic              flush;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_pc;
  logic [31:0]       res_target;
  logic              res_taken;
  logic              res_is_cond;
  logic              drain_hold;
  logic              update_valid;
  logic [31:0]       update_pc;
  logic [31:0]       update_target;
  logic              update_is_branch;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output flush, res_valid, res_pc, res_target, res_taken, res_is_cond, drain_hold,
    input  res_ready, update_valid, update_pc, update_target, update_is_branch, occupancy
  );

  modport slave (
    input  flush, res_valid, res_pc, res_target, res_taken, res_is_cond, drain_hold,
    output res_ready, update_valid, update_pc, update_target, update_is_branch, occupancy
  );
endinterface

// File: rtl/branch_update_queue.sv
// FIFO of taken-branch outcomes that drains one entry per cycle into the BTB update port.
// Optional macro BUQ_COALESCE_EN: a taken record whose PC matches the tail overwrites it in place.
module branch_update_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_update_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] tgt_mem  [DEPTH];
  logic        cond_mem [DEPTH];

  logic             not_empty;
  logic             full;
  logic             pop;
  logic             accept_taken;
  logic             coalesce;
  logic             push;
  logic [DEPTH-1:0] push_sel;

  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == CNT_W'(DEPTH));

  // Ready deliberately ignores a same-cycle pop so the handshake never depends on drain_hold.
  assign bus.res_ready = rst_n && !full;
  assign pop           = rst_n && not_empty && !bus.drain_hold && !bus.flush;
  assign accept_taken  = bus.res_valid && bus.res_ready && !bus.flush && bus.res_taken;

`ifdef BUQ_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  logic [DEPTH-1:0] coal_sel;

  assign tail_ptr = wr_ptr_reg - PTR_W'(1);
  // A lone entry that is being written to the BTB this edge cannot be patched; push behind it instead.
  assign coalesce = accept_taken && not_empty && (pc_mem[tail_ptr] == bus.res_pc)
                    && !(pop && (count_reg == CNT_W'(1)));
`else
  assign coalesce = 1'b0;
`endif

  assign push = accept_taken && !coalesce;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign push_sel[gi] = push && (wr_ptr_reg == PTR_W'(gi));
`ifdef BUQ_COALESCE_EN
    assign coal_sel[gi] = coalesce && (tail_ptr == PTR_W'(gi));
`endif
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (pop && !push) count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_sel[i]) begin
        pc_mem[i]   <= bus.res_pc;
        tgt_mem[i]  <= bus.res_target;
        cond_mem[i] <= bus.res_is_cond;
      end
`ifdef BUQ_COALESCE_EN
      else if (coal_sel[i]) begin
        tgt_mem[i]  <= bus.res_target;
        cond_mem[i] <= bus.res_is_cond;
      end
`endif
    end
  end

  assign bus.update_valid     = pop;
  assign bus.update_pc        = (rst_n && not_empty) ? pc_mem[rd_ptr_reg]   : 32'h0;
  assign bus.update_target    = (rst_n && not_empty) ? tgt_mem[rd_ptr_reg]  : 32'h0;
  assign bus.update_is_branch = rst_n && not_empty && cond_mem[rd_ptr_reg];
  assign bus.occupancy        = rst_n ? count_reg : '0;
endmodule
